// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable raster timing generator with shadowed timing set,
// selectable sync polarity, raster interrupts and frame/flash counter.
module video_timing_gen #(
   parameter int HW         = 10,
   parameter int VW         = 10,
   parameter int N_INT      = 2,
   parameter int FLASH_BITS = 5,
   parameter int DEF_HTOTAL = 448,
   parameter int DEF_VTOTAL = 320,
   parameter int MIN_TOTAL  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic                  cfg_wr,
   input  logic [HW-1:0]         cfg_htotal,
   input  logic [HW-1:0]         cfg_hs_beg,
   input  logic [HW-1:0]         cfg_hs_end,
   input  logic [HW-1:0]         cfg_ha_beg,
   input  logic [HW-1:0]         cfg_ha_end,
   input  logic [VW-1:0]         cfg_vtotal,
   input  logic [VW-1:0]         cfg_vs_beg,
   input  logic [VW-1:0]         cfg_vs_end,
   input  logic [VW-1:0]         cfg_va_beg,
   input  logic [VW-1:0]         cfg_va_end,
   input  logic                  cfg_hs_pol,
   input  logic                  cfg_vs_pol,
   input  logic [N_INT*HW-1:0]   int_h,
   input  logic [N_INT*VW-1:0]   int_v,
   input  logic [N_INT-1:0]      int_en,
   input  logic [N_INT-1:0]      int_ack,
   output logic [HW-1:0]         hcount,
   output logic [VW-1:0]         vcount,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  csync,
   output logic                  hblank,
   output logic                  vblank,
   output logic                  de,
   output logic                  line_start,
   output logic                  frame_start,
   output logic [N_INT-1:0]      int_pend,
   output logic [N_INT-1:0]      int_stb,
   output logic                  cfg_err,
   output logic [FLASH_BITS-1:0] frame_cnt,
   output logic                  flash
);

   typedef struct packed {
      logic [HW-1:0] ht, hsb, hse, hab, hae;
      logic [VW-1:0] vt, vsb, vse, vab, vae;
      logic          hp, vp;
   } tcfg_t;

   localparam tcfg_t DEF_CFG = '{ht: HW'(DEF_HTOTAL), hsb: HW'(11), hse: HW'(43),
                                 hab: HW'(88), hae: HW'(448),
                                 vt: VW'(DEF_VTOTAL), vsb: VW'(8), vse: VW'(11),
                                 vab: VW'(32), vae: VW'(320), hp: 1'b0, vp: 1'b0};

   tcfg_t         act_q, pend_q, act_d, cfg_in;
   logic          pend_vld_q;
   logic          h_wrap, v_wrap, f_wrap, load_try, pend_good;
   logic [HW-1:0] h_nxt;
   logic [VW-1:0] v_nxt;
   logic          hs_n, vs_n, ha_n, va_n;
   logic [N_INT-1:0] hit;

   always_comb begin
      cfg_in = '{ht: cfg_htotal, hsb: cfg_hs_beg, hse: cfg_hs_end, hab: cfg_ha_beg,
                 hae: cfg_ha_end, vt: cfg_vtotal, vsb: cfg_vs_beg, vse: cfg_vs_end,
                 vab: cfg_va_beg, vae: cfg_va_end, hp: cfg_hs_pol, vp: cfg_vs_pol};
   end

   assign h_wrap    = hcount >= act_q.ht - HW'(1);
   assign v_wrap    = vcount >= act_q.vt - VW'(1);
   assign f_wrap    = h_wrap & v_wrap;
   assign h_nxt     = h_wrap ? '0 : hcount + HW'(1);
   assign v_nxt     = !h_wrap ? vcount : (v_wrap ? '0 : vcount + VW'(1));
   // A cfg_wr coinciding with the wrap supersedes the old pending set, so nothing loads then.
   assign load_try  = ce & f_wrap & pend_vld_q & ~cfg_wr;
   assign pend_good = (pend_q.ht >= HW'(MIN_TOTAL)) && (pend_q.vt >= VW'(MIN_TOTAL));
   assign act_d     = (load_try & pend_good) ? pend_q : act_q;

   // Decode the position the counters move to, using the set that will be active there.
   assign hs_n = (h_nxt >= act_d.hsb) && (h_nxt < act_d.hse);
   assign vs_n = (v_nxt >= act_d.vsb) && (v_nxt < act_d.vse);
   assign ha_n = (h_nxt >= act_d.hab) && (h_nxt < act_d.hae);
   assign va_n = (v_nxt >= act_d.vab) && (v_nxt < act_d.vae);

   always_comb begin
      hit = '0;
      for (int i = 0; i < N_INT; i++)
         hit[i] = int_en[i] && (h_nxt == int_h[i*HW +: HW]) && (v_nxt == int_v[i*VW +: VW]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount      <= '0;
         vcount      <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         csync       <= 1'b1;
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         int_stb     <= '0;
         frame_cnt   <= '0;
         act_q       <= DEF_CFG;
      end else if (ce) begin
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         hsync       <= hs_n ^ ~act_d.hp;
         vsync       <= vs_n ^ ~act_d.vp;
         csync       <= ~(hs_n ^ vs_n) ^ act_d.hp;
         hblank      <= ~ha_n;
         vblank      <= ~va_n;
         de          <= ha_n & va_n;
         line_start  <= h_wrap;
         frame_start <= f_wrap;
         int_stb     <= hit;
         act_q       <= act_d;
         if (f_wrap)
            frame_cnt <= frame_cnt + FLASH_BITS'(1);
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         int_stb     <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= DEF_CFG;
         pend_vld_q <= 1'b0;
         cfg_err    <= 1'b0;
         int_pend   <= '0;
      end else begin
         if (cfg_wr) begin
            pend_q     <= cfg_in;
            pend_vld_q <= 1'b1;
         end else if (ce && f_wrap) begin
            pend_vld_q <= 1'b0;
         end
         if (load_try)
            cfg_err <= ~pend_good;
         int_pend <= (ce ? hit : '0) | (int_pend & ~int_ack);
      end
   end

   assign flash = frame_cnt[FLASH_BITS-1];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized bench for video_timing_gen against a raster model.
module tb_video_timing_gen;
   localparam int HW = 10, VW = 10, NI = 2, FB = 5, DVT = 40;

   logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, cfg_wr = 1'b0;
   logic [HW-1:0] cfg_htotal = '0, cfg_hs_beg = '0, cfg_hs_end = '0, cfg_ha_beg = '0, cfg_ha_end = '0;
   logic [VW-1:0] cfg_vtotal = '0, cfg_vs_beg = '0, cfg_vs_end = '0, cfg_va_beg = '0, cfg_va_end = '0;
   logic cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;
   logic [NI*HW-1:0] int_h = '0;
   logic [NI*VW-1:0] int_v = '0;
   logic [NI-1:0] int_en = '0, int_ack = '0;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic hsync, vsync, csync, hblank, vblank, de, line_start, frame_start, cfg_err, flash;
   logic [NI-1:0] int_pend, int_stb;
   logic [FB-1:0] frame_cnt;

   always #5 clk = ~clk;

   video_timing_gen #(.HW(HW), .VW(VW), .N_INT(NI), .FLASH_BITS(FB),
                      .DEF_HTOTAL(448), .DEF_VTOTAL(DVT), .MIN_TOTAL(16)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_wr(cfg_wr),
      .cfg_htotal(cfg_htotal), .cfg_hs_beg(cfg_hs_beg), .cfg_hs_end(cfg_hs_end),
      .cfg_ha_beg(cfg_ha_beg), .cfg_ha_end(cfg_ha_end),
      .cfg_vtotal(cfg_vtotal), .cfg_vs_beg(cfg_vs_beg), .cfg_vs_end(cfg_vs_end),
      .cfg_va_beg(cfg_va_beg), .cfg_va_end(cfg_va_end),
      .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
      .int_h(int_h), .int_v(int_v), .int_en(int_en), .int_ack(int_ack),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync), .csync(csync),
      .hblank(hblank), .vblank(vblank), .de(de), .line_start(line_start),
      .frame_start(frame_start), .int_pend(int_pend), .int_stb(int_stb),
      .cfg_err(cfg_err), .frame_cnt(frame_cnt), .flash(flash));

   typedef struct {
      int ht, hsb, hse, hab, hae, vt, vsb, vse, vab, vae;
      bit hp, vp;
   } mcfg_t;

   mcfg_t m_act, m_pend;
   int    m_h, m_v, m_fc;
   bit    m_pv, m_err, m_ls, m_fs;
   bit [NI-1:0] m_ipend, m_istb;
   int    n_chk = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit inr(int x, int b, int e);
      return (x >= b) && (x < e);
   endfunction

   task automatic model_reset();
      m_act = '{ht: 448, hsb: 11, hse: 43, hab: 88, hae: 448, vt: DVT, vsb: 8, vse: 11,
                vab: 32, vae: 320, hp: 1'b0, vp: 1'b0};
      m_pend = m_act;
      m_h = 0; m_v = 0; m_fc = 0;
      m_pv = 0; m_err = 0; m_ls = 0; m_fs = 0;
      m_ipend = '0; m_istb = '0;
   endtask

   task automatic model_step();
      bit lw, fw;
      int nh, nv;
      if (ce) begin
         lw = (m_h == m_act.ht - 1);
         fw = lw && (m_v == m_act.vt - 1);
         nh = lw ? 0 : m_h + 1;
         nv = lw ? (fw ? 0 : m_v + 1) : m_v;
         if (fw && m_pv && !cfg_wr) begin
            if (m_pend.ht >= 16 && m_pend.vt >= 16) begin
               m_act = m_pend;
               m_err = 0;
            end else
               m_err = 1;
         end
         if (fw) begin
            m_pv = 0;
            m_fc = (m_fc + 1) % (1 << FB);
         end
         for (int i = 0; i < NI; i++)
            m_istb[i] = int_en[i] && (nh == int'(int_h[i*HW +: HW])) && (nv == int'(int_v[i*VW +: VW]));
         m_ls = lw; m_fs = fw; m_h = nh; m_v = nv;
      end else begin
         m_istb = '0; m_ls = 0; m_fs = 0;
      end
      for (int i = 0; i < NI; i++)
         m_ipend[i] = m_istb[i] | (m_ipend[i] & !int_ack[i]);
      if (cfg_wr) begin
         m_pend = '{ht: int'(cfg_htotal), hsb: int'(cfg_hs_beg), hse: int'(cfg_hs_end),
                    hab: int'(cfg_ha_beg), hae: int'(cfg_ha_end), vt: int'(cfg_vtotal),
                    vsb: int'(cfg_vs_beg), vse: int'(cfg_vs_end), vab: int'(cfg_va_beg),
                    vae: int'(cfg_va_end), hp: cfg_hs_pol, vp: cfg_vs_pol};
         m_pv = 1;
      end
   endtask

   function automatic logic [38:0] exp_vec();
      bit hs, vs, hb, vb;
      logic [FB-1:0] fc;
      hs = inr(m_h, m_act.hsb, m_act.hse);
      vs = inr(m_v, m_act.vsb, m_act.vse);
      hb = !inr(m_h, m_act.hab, m_act.hae);
      vb = !inr(m_v, m_act.vab, m_act.vae);
      fc = FB'(m_fc);
      return {10'(m_h), 10'(m_v), m_act.hp ? hs : !hs, m_act.vp ? vs : !vs,
              m_act.hp ? (hs ^ vs) : !(hs ^ vs), hb, vb, !hb && !vb,
              m_ls, m_fs, m_ipend, m_istb, m_err, fc, fc[FB-1]};
   endfunction

   wire [38:0] dut_vec = {hcount, vcount, hsync, vsync, csync, hblank, vblank, de,
                          line_start, frame_start, int_pend, int_stb, cfg_err, frame_cnt, flash};

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("cyc", 64'(dut_vec), 64'(exp_vec()));
   endtask

   task automatic rand_cfg(input bit bad);
      int ht, vt;
      ht = bad ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 40));
      vt = (bad && $urandom_range(0, 1) == 1) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 30));
      cfg_htotal = HW'(ht);
      cfg_vtotal = VW'(vt);
      cfg_hs_beg = HW'($urandom_range(0, ht)); cfg_hs_end = HW'($urandom_range(0, ht));
      cfg_ha_beg = HW'($urandom_range(0, ht)); cfg_ha_end = HW'($urandom_range(0, ht));
      cfg_vs_beg = VW'($urandom_range(0, vt)); cfg_vs_end = VW'($urandom_range(0, vt));
      cfg_va_beg = VW'($urandom_range(0, vt)); cfg_va_end = VW'($urandom_range(0, vt));
      cfg_hs_pol = 1'($urandom_range(0, 1));
      cfg_vs_pol = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++) begin
         int_h[i*HW +: HW] = HW'($urandom_range(0, ht + 2));
         int_v[i*VW +: VW] = VW'($urandom_range(0, vt + 2));
      end
      int_en = NI'($urandom);
   endtask

   initial begin
      int fc0, wr_at, ce_w;
      bit  done;
      model_reset();
      #12;
      check("rst_hcount", 64'(hcount), 64'(0));
      check("rst_vcount", 64'(vcount), 64'(0));
      check("rst_hsync", 64'(hsync), 64'(1));
      check("rst_vsync", 64'(vsync), 64'(1));
      check("rst_csync", 64'(csync), 64'(1));
      check("rst_blank", 64'({hblank, vblank, de}), 64'(3'b110));
      check("rst_misc", 64'({line_start, frame_start, int_pend, int_stb, cfg_err, frame_cnt}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Default timing with ce held high, then a mid-frame reprogram.
      ce = 1'b1;
      for (int c = 0; c < 1200; c++) cycle();
      rand_cfg(1'b0);
      cfg_wr = 1'b1;
      cycle();
      cfg_wr = 1'b0;
      fc0 = m_fc;
      done = 0;
      for (int c = 0; c < 20000 && !done; c++) begin
         cycle();
         done = (m_fc != fc0);
      end
      check("first_wrap_seen", 64'(done), 64'(1));

      // Random phases: valid/invalid sets, random ce density, acks, wrap-coincident writes.
      for (int k = 0; k < 12; k++) begin
         rand_cfg(k % 4 == 1);
         wr_at = int'($urandom_range(0, 400));
         ce_w  = (k % 3 == 0) ? 1 : int'($urandom_range(2, 4));
         for (int c = 0; c < 3000; c++) begin
            ce = (ce_w == 1) ? 1'b1 : ($urandom_range(1, ce_w) != 1);
            int_ack = ($urandom_range(0, 7) == 0) ? NI'($urandom) : '0;
            if (k == 5)
               cfg_wr = ce && (m_h == m_act.ht - 1) && (m_v == m_act.vt - 1) && m_pv;
            else
               cfg_wr = (c == wr_at);
            if (k == 5 && cfg_wr) rand_cfg(c % 2 == 0);
            cycle();
         end
         cfg_wr = 1'b0;
         int_ack = '0;
         if (k == 4) begin
            rand_cfg(1'b0);
            cfg_wr = 1'b1;
            cycle();
            cfg_wr = 1'b0;
         end
      end

      // Asynchronous reset mid-frame with interrupts pending.
      ce = 1'b1;
      int_en = '1;
      int_ack = '0;
      for (int i = 0; i < NI; i++) begin
         int_h[i*HW +: HW] = HW'(i + 1);
         int_v[i*VW +: VW] = '0;
      end
      done = 0;
      for (int c = 0; c < 5000 && !done; c++) begin
         cycle();
         done = (m_ipend != '0) && (m_v > 2);
      end
      check("pend_before_rst", 64'(done), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_counts", 64'({hcount, vcount}), 64'(0));
      check("arst_pend", 64'({int_pend, int_stb, frame_cnt, cfg_err}), 64'(0));
      check("arst_vec", 64'(dut_vec), 64'(exp_vec()));
      @(negedge clk);
      rst_n = 1'b1;
      int_en = '0;
      for (int c = 0; c < 600; c++) cycle();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
